alu_arbiter: RTL

- Shares one instance of the team's 32-bit alu between two requesters, m0 and m1, using round-robin arbitration.
- Each requester gets a valid/ready request channel and a registered valid/ready response channel. Results return one cycle after acceptance.
- Sits between the decode/issue logic and the ALU. Lets a second agent use the datapath without a second ALU; the second agent is an address-generation or debug unit.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 29 ++
 rtl/alu_rsp_slot.sv | 35 +++
 rtl/alu_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, width and legality helper
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_SLL = 3'b100;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL: is_legal_op = 1'b1;
      default:                                             is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with zero and illegal-op flags
module alu
  import alu_pkg::*;
(
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL: result = a << b[4:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign err  = !is_legal_op(op);

endmodule

// File: rtl/alu_rsp_slot.sv
// rtl/alu_rsp_slot.sv - per-requester registered response holding slot
module alu_rsp_slot
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_result,
  input  logic             ld_zero,
  input  logic             ld_err,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  // A load wins over a drain so back-to-back results keep valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (load) begin
      rsp_valid  <= 1'b1;
      rsp_result <= ld_result;
      rsp_zero   <= ld_zero;
      rsp_err    <= ld_err;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req_valid,
  output logic             m0_req_ready,
  input  logic [2:0]       m0_op,
  input  logic [WIDTH-1:0] m0_a,
  input  logic [WIDTH-1:0] m0_b,
  output logic             m0_rsp_valid,
  input  logic             m0_rsp_ready,
  output logic [WIDTH-1:0] m0_rsp_result,
  output logic             m0_rsp_zero,
  output logic             m0_rsp_err,
  input  logic             m1_req_valid,
  output logic             m1_req_ready,
  input  logic [2:0]       m1_op,
  input  logic [WIDTH-1:0] m1_a,
  input  logic [WIDTH-1:0] m1_b,
  output logic             m1_rsp_valid,
  input  logic             m1_rsp_ready,
  output logic [WIDTH-1:0] m1_rsp_result,
  output logic             m1_rsp_zero,
  output logic             m1_rsp_err
);

  logic             prio;
  logic             free0, free1, elig0, elig1, grant0, grant1;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero, alu_err;

  // A slot whose response drains this cycle can accept a new result.
  assign free0 = !m0_rsp_valid || m0_rsp_ready;
  assign free1 = !m1_rsp_valid || m1_rsp_ready;
  assign elig0 = m0_req_valid && free0;
  assign elig1 = m1_req_valid && free1;

  assign grant0 = elig0 && (!elig1 || (prio == 1'b0));
  assign grant1 = elig1 && (!elig0 || (prio == 1'b1));

  assign m0_req_ready = grant0;
  assign m1_req_ready = grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       prio <= 1'(RR_INIT);
    else if (grant0) prio <= 1'b1;
    else if (grant1) prio <= 1'b0;
  end

  always_comb begin
    alu_op = 3'b000;
    alu_a  = '0;
    alu_b  = '0;
    if (grant0) begin
      alu_op = m0_op;
      alu_a  = m0_a;
      alu_b  = m0_b;
    end else if (grant1) begin
      alu_op = m1_op;
      alu_a  = m1_a;
      alu_b  = m1_b;
    end
  end

  alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  alu_rsp_slot u_slot0 (
    .clk        (clk),
    .reset      (reset),
    .load       (grant0),
    .ld_result  (alu_result),
    .ld_zero    (alu_zero),
    .ld_err     (alu_err),
    .rsp_ready  (m0_rsp_ready),
    .rsp_valid  (m0_rsp_valid),
    .rsp_result (m0_rsp_result),
    .rsp_zero   (m0_rsp_zero),
    .rsp_err    (m0_rsp_err)
  );

  alu_rsp_slot u_slot1 (
    .clk        (clk),
    .reset      (reset),
    .load       (grant1),
    .ld_result  (alu_result),
    .ld_zero    (alu_zero),
    .ld_err     (alu_err),
    .rsp_ready  (m1_rsp_ready),
    .rsp_valid  (m1_rsp_valid),
    .rsp_result (m1_rsp_result),
    .rsp_zero   (m1_rsp_zero),
    .rsp_err    (m1_rsp_err)
  );

endmodule
